// File: rtl/dcache_wbuf.sv
// Posted write-back buffer between the data cache and line memory, with line-address matching for reads.
// Define DCACHE_WBUF_FORWARD_EN to forward buffered lines to matching reads instead of draining them first.
module dcache_wbuf #(
    parameter int DEPTH  = 2,
    parameter int LINE_W = 256,
    parameter int OFS_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cache_enable_i,
    input  logic              cache_write_i,
    input  logic [31:0]       cache_addr_i,
    input  logic [LINE_W-1:0] cache_data_i,
    output logic              cache_ack_o,
    output logic [LINE_W-1:0] cache_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i,
    output logic              empty_o,
    output logic [2:0]        count_o
);
    localparam int AW = 32 - OFS_W;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;

    state_t            state_q, state_d;
    logic [2:0]        count_q;
    logic              ack_q;
    logic [LINE_W-1:0] rdata_q;
    logic [AW-1:0]     rd_line_q;
    logic [AW-1:0]     ent_addr [DEPTH];
    logic [LINE_W-1:0] ent_data [DEPTH];

    logic [AW-1:0]     req_line;
    logic              unused_ofs;
    logic              rd_hit, wr_hit;
    logic [2:0]        wr_hit_idx, wr_idx;
    logic [LINE_W-1:0] rd_data;
    logic              req_live, wr_accept, rd_fwd, rd_miss, drain_done, alloc;

    assign req_line   = cache_addr_i[31:OFS_W];
    assign unused_ofs = ^cache_addr_i[OFS_W-1:0];

    // Entry 0 is the oldest; the loop lets the youngest read match win,
    // while the in-flight head is excluded as a coalescing target.
    always_comb begin
        rd_hit     = 1'b0;
        wr_hit     = 1'b0;
        wr_hit_idx = '0;
        rd_data    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (3'(i) < count_q && ent_addr[i] == req_line) begin
                rd_hit  = 1'b1;
                rd_data = ent_data[i];
                if (!(i == 0 && state_q == DRAIN)) begin
                    wr_hit     = 1'b1;
                    wr_hit_idx = 3'(i);
                end
            end
        end
    end

    assign req_live   = cache_enable_i && !ack_q && (state_q == IDLE || state_q == DRAIN);
    assign wr_accept  = req_live && cache_write_i && (wr_hit || count_q < DEPTH_C);
    assign alloc      = wr_accept && !wr_hit;
    assign drain_done = (state_q == DRAIN) && mem_ack_i;
    assign rd_miss    = req_live && !cache_write_i && !rd_hit;
`ifdef DCACHE_WBUF_FORWARD_EN
    assign rd_fwd     = req_live && !cache_write_i && rd_hit;
`else
    assign rd_fwd     = 1'b0;
`endif
    // A completing drain shifts every entry down by one in the same edge.
    assign wr_idx = (wr_hit ? wr_hit_idx : count_q) - {2'b00, drain_done};

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [AW-1:0]     addr_r, up_addr;
        logic [LINE_W-1:0] data_r, up_data;
        if (g < DEPTH - 1) begin : g_up
            assign up_addr = ent_addr[g+1];
            assign up_data = ent_data[g+1];
        end else begin : g_top
            assign up_addr = addr_r;
            assign up_data = data_r;
        end
        always_ff @(posedge clk_i) begin
            if (wr_accept && wr_idx == 3'(g)) begin
                addr_r <= req_line;
                data_r <= cache_data_i;
            end else if (drain_done) begin
                addr_r <= up_addr;
                data_r <= up_data;
            end
        end
        assign ent_addr[g] = addr_r;
        assign ent_data[g] = data_r;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_miss)
                    state_d = READ;
                else if (count_q != 3'd0)
                    state_d = DRAIN;
            end
            DRAIN: if (mem_ack_i) state_d = IDLE;
            READ:  if (mem_ack_i) state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            rd_line_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_q + {2'b00, alloc} - {2'b00, drain_done};
            ack_q   <= wr_accept || rd_fwd || (state_q == READ && mem_ack_i);
            if (rd_fwd)
                rdata_q <= rd_data;
            else if (state_q == READ && mem_ack_i)
                rdata_q <= mem_data_i;
            if (state_q == IDLE && state_d == READ)
                rd_line_q <= req_line;
        end
    end

    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            DRAIN: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {ent_addr[0], {OFS_W{1'b0}}};
                mem_data_o   = ent_data[0];
            end
            READ: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {rd_line_q, {OFS_W{1'b0}}};
            end
            default: ;
        endcase
    end

    assign cache_ack_o  = ack_q;
    assign cache_data_o = rdata_q;
    assign count_o      = count_q;
    assign empty_o      = (count_q == 3'd0) && (state_q == IDLE);
endmodule

// File: tb/tb_dcache_wbuf.sv
// Scoreboard bench for dcache_wbuf: reads must always return the latest line written by the cache.
// The bench models memory as a slow slave with a line-indexed store and logs every transaction.
module tb_dcache_wbuf;
    localparam int LW = 256;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cache_enable_i, cache_write_i;
    logic [31:0]   cache_addr_i;
    logic [LW-1:0] cache_data_i;
    logic          cache_ack_o;
    logic [LW-1:0] cache_data_o;
    logic          mem_enable_o, mem_write_o;
    logic [31:0]   mem_addr_o;
    logic [LW-1:0] mem_data_o;
    logic          mem_ack_i;
    logic [LW-1:0] mem_data_i;
    logic          empty_o;
    logic [2:0]    count_o;

    always #5 clk_i = ~clk_i;

    dcache_wbuf dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cache_enable_i(cache_enable_i), .cache_write_i(cache_write_i),
        .cache_addr_i(cache_addr_i), .cache_data_i(cache_data_i),
        .cache_ack_o(cache_ack_o), .cache_data_o(cache_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .empty_o(empty_o), .count_o(count_o)
    );

    typedef struct {bit is_read; logic [LW-1:0] data;} exp_t;
    typedef struct {bit wr; logic [31:0] addr;} txn_t;

    int            errors = 0;
    int            checks = 0;
    exp_t          exp_q[$];
    txn_t          mem_log[$];
    logic [LW-1:0] mem_arr [int];
    logic [LW-1:0] ref_arr [int];
    int            mem_lat = 1;
    bit            mem_rand = 0;

    function automatic logic [LW-1:0] init_line(input int line);
        logic [LW-1:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = 32'hC0DE_0000 + 32'(line * 8 + k);
        return v;
    endfunction

    function automatic logic [LW-1:0] mem_rd(input int line);
        return mem_arr.exists(line) ? mem_arr[line] : init_line(line);
    endfunction

    function automatic logic [LW-1:0] ref_rd(input int line);
        return ref_arr.exists(line) ? ref_arr[line] : init_line(line);
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [32:0] logAt(input int i);
        if (i < mem_log.size()) return {mem_log[i].wr, mem_log[i].addr};
        return '1;
    endfunction

    task automatic checkOutput(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [LW-1:0] data,
                                 output int cyc);
        exp_t e;
        int   line;
        line = int'(addr[31:5]);
        @(posedge clk_i); #1;
        e.is_read = !wr;
        if (wr) begin
            ref_arr[line] = data;
            e.data = '0;
        end else begin
            e.data = ref_rd(line);
        end
        exp_q.push_back(e);
        cache_enable_i = 1'b1;
        cache_write_i  = wr;
        cache_addr_i   = addr;
        cache_data_i   = wr ? data : '0;
        cyc = 0;
        do begin
            @(negedge clk_i);
            cyc++;
        end while (!cache_ack_o && cyc < 3000);
        if (!cache_ack_o) begin
            errors++;
            checks++;
            $display("[TB] FAIL ack_timeout: got no ack in %0d cycles, required ack for addr %h", cyc, addr);
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
        @(posedge clk_i); #1;
        cache_enable_i = 1'b0;
        cache_write_i  = 1'b0;
    endtask

    task automatic waitDrained();
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!empty_o && n < 5000);
        checkOutput("drain_complete", empty_o, 1);
    endtask

    // Scoreboard monitor: every ack consumes the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && cache_ack_o) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("[TB] FAIL unexpected_ack: got ack with no request outstanding, required none");
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_read) checkOutput("read_data", cache_data_o, e.data);
                end
            end
        end
    end

    // Memory slave: captures a request, holds it for a latency, then pulses mem_ack_i.
    initial begin
        bit            busy = 0;
        int            wait_cnt = 0;
        bit            cap_wr;
        logic [31:0]   cap_addr;
        logic [LW-1:0] cap_data;
        txn_t          t;
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                busy = 0;
                mem_ack_i = 1'b0;
            end else if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                busy = 0;
            end else if (busy) begin
                checkOutput("mem_enable_held", mem_enable_o, 1);
                checkOutput("mem_addr_stable", mem_addr_o, cap_addr);
                checkOutput("mem_write_stable", mem_write_o, cap_wr);
                checkOutput("mem_data_stable", mem_data_o, cap_data);
                if (wait_cnt == 0) begin
                    if (cap_wr) mem_arr[int'(cap_addr[31:5])] = cap_data;
                    else        mem_data_i = mem_rd(int'(cap_addr[31:5]));
                    t.wr = cap_wr;
                    t.addr = cap_addr;
                    mem_log.push_back(t);
                    mem_ack_i = 1'b1;
                end else begin
                    wait_cnt--;
                end
            end else if (mem_enable_o) begin
                cap_wr   = mem_write_o;
                cap_addr = mem_addr_o;
                cap_data = mem_data_o;
                checkOutput("mem_addr_aligned", mem_addr_o[4:0], 0);
                busy = 1;
                wait_cnt = mem_rand ? int'($urandom_range(1, 5)) : mem_lat;
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no completion, required finish within budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            cyc;
        int            n;
        bit            flag;
        logic [LW-1:0] d_a, d_b;

        rst_i = 1'b1;
        cache_enable_i = 1'b0;
        cache_write_i = 1'b0;
        cache_addr_i = '0;
        cache_data_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_cache_ack", cache_ack_o, 0);
        checkOutput("rst_mem_enable", mem_enable_o, 0);
        checkOutput("rst_mem_write", mem_write_o, 0);
        checkOutput("rst_mem_addr", mem_addr_o, 0);
        checkOutput("rst_mem_data", mem_data_o, 0);
        checkOutput("rst_cache_data", cache_data_o, 0);
        checkOutput("rst_count", count_o, 0);
        checkOutput("rst_empty", empty_o, 1);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        $display("[TB] posted write latency");
        mem_lat = 3;
        d_a = rand_line();
        applyStimulus(1, 32'h0400, d_a, cyc);
        checkOutput("write_ack_latency", cyc, 2);
        waitDrained();
        checkOutput("drain_data_0400", mem_rd(32), d_a);

        $display("[TB] read has priority over queued drain");
        mem_log.delete();
        mem_lat = 20;
        applyStimulus(1, 32'h0800, rand_line(), cyc);
        applyStimulus(1, 32'h0400, rand_line(), cyc);
        applyStimulus(0, 32'h0000, '0, cyc);
        waitDrained();
        checkOutput("prio_order0", logAt(0), {1'b1, 32'h0800});
        checkOutput("prio_order1", logAt(1), {1'b0, 32'h0000});
        checkOutput("prio_order2", logAt(2), {1'b1, 32'h0400});

        $display("[TB] read matching a buffered line");
        mem_log.delete();
        d_a = rand_line();
        applyStimulus(1, 32'h0040, d_a, cyc);
        applyStimulus(0, 32'h0040, '0, cyc);
        waitDrained();
`ifdef DCACHE_WBUF_FORWARD_EN
        checkOutput("fwd_ack_latency", cyc, 2);
        checkOutput("fwd_log_size", mem_log.size(), 1);
`else
        checkOutput("match_order0", logAt(0), {1'b1, 32'h0040});
        checkOutput("match_order1", logAt(1), {1'b0, 32'h0040});
`endif

        $display("[TB] full buffer stall");
        mem_log.delete();
        mem_lat = 30;
        applyStimulus(1, 32'h0000, rand_line(), cyc);
        applyStimulus(1, 32'h0200, rand_line(), cyc);
        checkOutput("count_full", count_o, 2);
        applyStimulus(1, 32'h0400, rand_line(), cyc);
        flag = (mem_log.size() >= 1);
        checkOutput("third_write_waits_drain", flag, 1);
        waitDrained();
        checkOutput("stall_order0", logAt(0), {1'b1, 32'h0000});
        checkOutput("stall_order1", logAt(1), {1'b1, 32'h0200});
        checkOutput("stall_order2", logAt(2), {1'b1, 32'h0400});

        $display("[TB] coalescing a queued line");
        mem_log.delete();
        d_b = rand_line();
        applyStimulus(1, 32'h0800, rand_line(), cyc);
        applyStimulus(1, 32'h0200, rand_line(), cyc);
        applyStimulus(1, 32'h0204, d_b, cyc);
        checkOutput("coalesce_count", count_o, 2);
        waitDrained();
        checkOutput("coalesce_log_size", mem_log.size(), 2);
        checkOutput("coalesce_order1", logAt(1), {1'b1, 32'h0200});
        checkOutput("coalesce_data", mem_rd(16), d_b);

        $display("[TB] write to an in-flight line");
        mem_log.delete();
        d_a = rand_line();
        d_b = rand_line();
        applyStimulus(1, 32'h0200, d_a, cyc);
        applyStimulus(1, 32'h0200, d_b, cyc);
        checkOutput("inflight_count", count_o, 2);
        n = 0;
        while (mem_log.size() < 1 && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("inflight_count_after_first", count_o, 1);
        waitDrained();
        checkOutput("inflight_order0", logAt(0), {1'b1, 32'h0200});
        checkOutput("inflight_order1", logAt(1), {1'b1, 32'h0200});
        checkOutput("inflight_data", mem_rd(16), d_b);

        $display("[TB] read waits for an unrelated drain");
        mem_log.delete();
        mem_lat = 20;
        applyStimulus(1, 32'h0000, rand_line(), cyc);
        applyStimulus(0, 32'h0220, '0, cyc);
        waitDrained();
        checkOutput("rd_wait_order0", logAt(0), {1'b1, 32'h0000});
        checkOutput("rd_wait_order1", logAt(1), {1'b0, 32'h0220});

        $display("[TB] reset during a drain");
        applyStimulus(1, 32'h0600, rand_line(), cyc);
        n = 0;
        while (!mem_enable_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("drain_started", mem_enable_o, 1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("midrst_mem_enable", mem_enable_o, 0);
        checkOutput("midrst_count", count_o, 0);
        checkOutput("midrst_empty", empty_o, 1);
        checkOutput("midrst_cache_ack", cache_ack_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        ref_arr = mem_arr;

        $display("[TB] randomized traffic");
        mem_rand = 1;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] addr;
            bit          wr;
            addr = (32'($urandom_range(0, 7)) << 5) | 32'($urandom_range(0, 31));
            wr = bit'($urandom_range(0, 1));
            applyStimulus(wr, addr, rand_line(), cyc);
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
        end
        waitDrained();
        foreach (ref_arr[k]) checkOutput("final_memory", mem_rd(k), ref_arr[k]);
        checkOutput("final_count", count_o, 0);
        checkOutput("final_scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
